csr_reg_bank: RTL and testbench
===============================

// Module: csr_reg_bank
// PURPOSE
//   Parametrised CSR register bank for the HDC core: holds NumRegs control/status registers, serves
//   a valid/ready host request port with one outstanding access, and exposes every register to core
//   logic. Per-register access modes (RW, RO, W1C, write-auto-clear) replace fixed per-bit CSR wiring;
//   e.g. CORE_SET start bit = WAC, AM prediction/PC = RO, sticky valid flags = W1C.
// PARAMETERS
//   NumRegs    16              number of CSRs, addressed 0..NumRegs-1
//   DataWidth  32              register width, multiple of 8
//   RegAccess  '0              packed [NumRegs*2]: 2'b00 RW, 2'b01 RO, 2'b10 W1C, 2'b11 WAC (reg i at bits 2i+:2)
//   ResetVal   '0              packed [NumRegs*DataWidth]: reset value of reg i at i*DataWidth+:DataWidth
// PORTS
//   clk_i          in   1                    clock
//   rst_i          in   1                    async reset, active-high
//   req_valid_i    in   1                    host request valid
//   req_ready_o    out  1                    bank accepts request
//   req_addr_i     in   32                   register index
//   req_write_i    in   1                    1 write, 0 read
//   req_wdata_i    in   DataWidth            write data
//   req_strb_i     in   DataWidth/8          byte write enables
//   rsp_valid_o    out  1                    response valid
//   rsp_ready_i    in   1                    host takes response
//   rsp_rdata_o    out  DataWidth            read data (0 for writes/errors)
//   rsp_err_o      out  1                    access error
//   hw_wr_en_i     in   NumRegs              per-reg hardware update strobe
//   hw_wr_data_i   in   NumRegs*DataWidth    hardware update data
//   csr_q_o        out  NumRegs*DataWidth    current register contents
// BEHAVIOUR
//   Reset: regs = ResetVal; FSM IDLE; req_ready_o=1 after reset release, 0 while rst_i high;
//     rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0.
//   FSM: IDLE (req_ready_o=1) --req_valid_i--> RESP (req_ready_o=0, rsp_valid_o=1);
//     RESP --rsp_ready_i--> IDLE. Response appears exactly 1 cycle after accept; rsp_* held stable
//     until taken. Next request is accepted no earlier than the cycle after rsp handshake.
//   Accept edge: write side effects applied; read data = register value before that edge.
//   Errors (rsp_err_o=1, no state change, rdata=0): req_addr_i >= NumRegs; write to RO reg.
//   Byte mask: only bytes with req_strb_i set are affected; strb=0 write is a legal no-op, err=0.
//   RW : sw write loads masked bytes; hw_wr_en_i loads full word; same cycle -> sw wins.
//   RO : sw write -> error; hw_wr_en_i loads full word.
//   W1C: sw write clears bits where wdata=1 (masked); hw_wr_en_i ORs hw_wr_data_i in;
//        same cycle same bit -> hw set wins (event never lost).
//   WAC: sw write loads masked bytes for exactly one cycle, then reg returns to 0 next cycle;
//        hw_wr_en_i ignored; reads return current value (normally 0).
//   csr_q_o reflects register state combinationally from flops (0-cycle read path to core).
//   Reset asserted mid-transaction: pending response dropped, rsp_valid_o=0 immediately, regs reset.
//   req_addr_i upper bits beyond $clog2(NumRegs) are checked (never aliased).
// TESTING
//   1 Reset: RegAccess reg0=RW, ResetVal reg0=32'hA5 -> csr_q_o[31:0]=32'hA5, req_ready_o=1,
//     rsp_valid_o=0.
//   2 RW write/read: write reg3=32'hDEADBEEF strb=4'b0011 over 0 -> read returns 32'h0000BEEF,
//     rsp 1 cycle after accept, err=0; hold rsp_ready_i=0 3 cycles -> rsp stable, req_ready_o=0.
//   3 W1C: hw sets reg5 bit0 and bit8; sw writes 32'h1 same cycle hw re-sets bit0 -> reg5=32'h101;
//     next sw write 32'h101 -> reg5=0.
//   4 WAC start: write reg0=32'h1 -> csr_q_o[0]=1 for exactly one cycle, then 0.
//   5 Errors: read addr 16 (NumRegs=16) -> err=1, rdata=0; write RO reg2 -> err=1, reg unchanged.
//   6 Reset mid-op: assert rst_i while rsp_valid_o=1 -> rsp_valid_o=0 same cycle, regs=ResetVal.

Source files
------------

// File: rtl/csr_reg_bank.sv
// csr_reg_bank: parametrised CSR bank for the HDC core.
// The host port is valid/ready with one outstanding access. Each register has its own access
// mode (RW, RO, W1C, write-auto-clear), and every register is exposed flat to core logic.
module csr_reg_bank #(
    parameter int unsigned                    NumRegs   = 16,
    parameter int unsigned                    DataWidth = 32,
    parameter logic [NumRegs*2-1:0]           RegAccess = '0,
    parameter logic [NumRegs*DataWidth-1:0]   ResetVal  = '0
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              req_valid_i,
    output logic                              req_ready_o,
    input  logic [31:0]                       req_addr_i,
    input  logic                              req_write_i,
    input  logic [DataWidth-1:0]              req_wdata_i,
    input  logic [DataWidth/8-1:0]            req_strb_i,
    output logic                              rsp_valid_o,
    input  logic                              rsp_ready_i,
    output logic [DataWidth-1:0]              rsp_rdata_o,
    output logic                              rsp_err_o,
    input  logic [NumRegs-1:0]                hw_wr_en_i,
    input  logic [NumRegs*DataWidth-1:0]      hw_wr_data_i,
    output logic [NumRegs*DataWidth-1:0]      csr_q_o
);

    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam int unsigned IdxWidth  = (NumRegs > 1) ? $clog2(NumRegs) : 1;

    localparam logic [1:0] ACC_RW  = 2'b00;
    localparam logic [1:0] ACC_RO  = 2'b01;
    localparam logic [1:0] ACC_W1C = 2'b10;
    localparam logic [1:0] ACC_WAC = 2'b11;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RESP = 1'b1;

    logic [0:0]           state_q, state_d;
    logic [DataWidth-1:0] regs_q [NumRegs];
    logic [DataWidth-1:0] regs_d [NumRegs];
    logic [DataWidth-1:0] rdata_q, rdata_d;
    logic                 err_q, err_d;

    logic [DataWidth-1:0] wmask;
    logic [IdxWidth-1:0]  idx;
    logic                 addr_ok;
    logic [1:0]           sel_acc;
    logic [DataWidth-1:0] sel_val;
    logic                 req_err;
    logic                 accept;
    logic [NumRegs-1:0]   sw_wr;

    // Full address compare so out-of-range upper bits never alias onto a real register
    assign addr_ok = (req_addr_i < 32'(NumRegs));
    assign idx     = req_addr_i[IdxWidth-1:0];

    // Ready is withheld while reset is held so nothing is accepted into a bank being reset
    assign req_ready_o = (state_q == ST_IDLE) && !rst_i;
    assign rsp_valid_o = (state_q == ST_RESP);
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;
    assign accept      = req_valid_i && req_ready_o;

    // Expand byte strobes into a bit mask
    always_comb begin
        wmask = '0;
        for (int unsigned b = 0; b < StrbWidth; b++) begin
            wmask[b*8 +: 8] = {8{req_strb_i[b]}};
        end
    end

    // Select access mode and current value of the addressed register
    always_comb begin
        sel_acc = ACC_RW;
        sel_val = '0;
        for (int unsigned i = 0; i < NumRegs; i++) begin
            if (idx == IdxWidth'(i)) begin
                sel_acc = RegAccess[2*i +: 2];
                sel_val = regs_q[i];
            end
        end
    end

    assign req_err = !addr_ok || (req_write_i && (sel_acc == ACC_RO));

    // Decode the one register that a legal software write touches
    always_comb begin
        sw_wr = '0;
        for (int unsigned i = 0; i < NumRegs; i++) begin
            sw_wr[i] = accept && req_write_i && !req_err && (idx == IdxWidth'(i));
        end
    end

    // Per-register next value according to its access mode
    always_comb begin
        for (int unsigned i = 0; i < NumRegs; i++) begin
            regs_d[i] = regs_q[i];
            case (RegAccess[2*i +: 2])
                ACC_RW: begin
                    if (sw_wr[i]) begin
                        regs_d[i] = (regs_q[i] & ~wmask) | (req_wdata_i & wmask);
                    end else if (hw_wr_en_i[i]) begin
                        regs_d[i] = hw_wr_data_i[i*DataWidth +: DataWidth];
                    end
                end
                ACC_RO: begin
                    if (hw_wr_en_i[i]) begin
                        regs_d[i] = hw_wr_data_i[i*DataWidth +: DataWidth];
                    end
                end
                ACC_W1C: begin
                    // Clear first, then OR the hardware set so a same-cycle event is never lost
                    regs_d[i] = regs_q[i] & ~(sw_wr[i] ? (req_wdata_i & wmask) : '0);
                    if (hw_wr_en_i[i]) begin
                        regs_d[i] = regs_d[i] | hw_wr_data_i[i*DataWidth +: DataWidth];
                    end
                end
                ACC_WAC: begin
                    regs_d[i] = sw_wr[i] ? ((regs_q[i] & ~wmask) | (req_wdata_i & wmask)) : '0;
                end
                default: regs_d[i] = regs_q[i];
            endcase
        end
    end

    // Handshake FSM and response capture; read data is the pre-edge register value
    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_RESP;
                    rdata_d = (!req_write_i && !req_err) ? sel_val : '0;
                    err_d   = req_err;
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    state_d = ST_IDLE;
                    rdata_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and register flops
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            rdata_q <= '0;
            err_q   <= 1'b0;
            for (int unsigned i = 0; i < NumRegs; i++) begin
                regs_q[i] <= ResetVal[i*DataWidth +: DataWidth];
            end
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            for (int unsigned i = 0; i < NumRegs; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Flat register view for core logic
    always_comb begin
        csr_q_o = '0;
        for (int unsigned i = 0; i < NumRegs; i++) begin
            csr_q_o[i*DataWidth +: DataWidth] = regs_q[i];
        end
    end

endmodule

// File: tb/tb_csr_reg_bank.sv
// tb_csr_reg_bank: directed checks of the CSR bank.
// u_dut: reg0 RW (reset 0xA5), reg2 RO (reset 0x1234), reg5 W1C, others RW.
// u_dut_wac: identical except reg0 is write-auto-clear; it shares all inputs with u_dut.
module tb_csr_reg_bank;

    localparam int unsigned NR = 16;
    localparam int unsigned DW = 32;

    localparam logic [NR*2-1:0]  ACC_MAIN = (32'b01 << 4) | (32'b10 << 10);
    localparam logic [NR*2-1:0]  ACC_WAC  = ACC_MAIN | 32'b11;
    localparam logic [NR*DW-1:0] RST_VAL  = (512'h1234 << 64) | 512'hA5;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [31:0]       req_addr = '0;
    logic              req_write = 1'b0;
    logic [DW-1:0]     req_wdata = '0;
    logic [DW/8-1:0]   req_strb = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [DW-1:0]     rsp_rdata;
    logic              rsp_err;
    logic [NR-1:0]     hw_en = '0;
    logic [NR*DW-1:0]  hw_data = '0;
    logic [NR*DW-1:0]  csr_q;

    logic              req_ready_w;
    logic              rsp_valid_w;
    logic [DW-1:0]     rsp_rdata_w;
    logic              rsp_err_w;
    logic [NR*DW-1:0]  csr_q_w;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    csr_reg_bank #(.NumRegs(NR), .DataWidth(DW), .RegAccess(ACC_MAIN), .ResetVal(RST_VAL)) u_dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
        .req_write_i(req_write), .req_wdata_i(req_wdata), .req_strb_i(req_strb),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
        .rsp_err_o(rsp_err), .hw_wr_en_i(hw_en), .hw_wr_data_i(hw_data), .csr_q_o(csr_q)
    );

    csr_reg_bank #(.NumRegs(NR), .DataWidth(DW), .RegAccess(ACC_WAC), .ResetVal(RST_VAL)) u_dut_wac (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready_w), .req_addr_i(req_addr),
        .req_write_i(req_write), .req_wdata_i(req_wdata), .req_strb_i(req_strb),
        .rsp_valid_o(rsp_valid_w), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata_w),
        .rsp_err_o(rsp_err_w), .hw_wr_en_i(hw_en), .hw_wr_data_i(hw_data), .csr_q_o(csr_q_w)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [DW-1:0] reg_of(input logic [NR*DW-1:0] v, input int unsigned i);
        return v[i*DW +: DW];
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present a request (called #1 after an edge), take the accept edge, expect response next
    task automatic issue(input string tag, input logic wr, input logic [31:0] addr,
                         input logic [DW-1:0] wd, input logic [DW/8-1:0] st);
        check_eq({tag, "_ready"}, req_ready, 1);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        req_strb  = st;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check_eq({tag, "_rsp_valid"}, rsp_valid, 1);
    endtask

    // Optionally stall the response, then check and take it
    task automatic complete(input string tag, input int unsigned hold,
                            input logic [DW-1:0] exp_rdata, input logic exp_err);
        for (int unsigned c = 0; c < hold; c++) begin
            @(posedge clk);
            #1;
            check_eq({tag, "_hold_valid"}, rsp_valid, 1);
            check_eq({tag, "_hold_rdata"}, rsp_rdata, exp_rdata);
            check_eq({tag, "_hold_ready"}, req_ready, 0);
        end
        check_eq({tag, "_rdata"}, rsp_rdata, exp_rdata);
        check_eq({tag, "_err"}, rsp_err, exp_err);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check_eq({tag, "_done_valid"}, rsp_valid, 0);
        check_eq({tag, "_done_ready"}, req_ready, 1);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_held_ready", req_ready, 0);
        check_eq("rst_held_rsp_valid", rsp_valid, 0);
        rst = 1'b0;
        #1;
        check_eq("rst_reg0", reg_of(csr_q, 0), 32'hA5);
        check_eq("rst_reg2", reg_of(csr_q, 2), 32'h1234);
        check_eq("rst_ready", req_ready, 1);
        check_eq("rst_rsp_valid", rsp_valid, 0);
        check_eq("rst_rdata", rsp_rdata, 0);
        check_eq("rst_err", rsp_err, 0);
        @(posedge clk);
        #1;

        // RW masked write, then read with a stalled response
        issue("rw_wr", 1'b1, 32'd3, 32'hDEADBEEF, 4'b0011);
        check_eq("rw_wr_reg3", reg_of(csr_q, 3), 32'h0000BEEF);
        complete("rw_wr", 0, 32'h0, 1'b0);
        issue("rw_rd", 1'b0, 32'd3, 32'h0, 4'h0);
        complete("rw_rd", 3, 32'h0000BEEF, 1'b0);

        // Zero-strobe write is a legal no-op
        issue("strb0", 1'b1, 32'd3, 32'hFFFFFFFF, 4'b0000);
        check_eq("strb0_reg3", reg_of(csr_q, 3), 32'h0000BEEF);
        complete("strb0", 0, 32'h0, 1'b0);

        // RW: software write beats a same-cycle hardware load
        hw_en[3] = 1'b1;
        hw_data[3*DW +: DW] = 32'hFFFFFFFF;
        issue("rw_swhw", 1'b1, 32'd3, 32'h12345678, 4'b1111);
        hw_en = '0;
        check_eq("rw_swhw_reg3", reg_of(csr_q, 3), 32'h12345678);
        complete("rw_swhw", 0, 32'h0, 1'b0);

        // RW: hardware load alone takes the full word
        hw_en[3] = 1'b1;
        hw_data[3*DW +: DW] = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        hw_en = '0;
        check_eq("rw_hw_reg3", reg_of(csr_q, 3), 32'hCAFEF00D);

        // W1C: hw sets, sw clear racing hw re-set, then full clear
        hw_en[5] = 1'b1;
        hw_data[5*DW +: DW] = 32'h101;
        @(posedge clk);
        #1;
        hw_en = '0;
        check_eq("w1c_set", reg_of(csr_q, 5), 32'h101);
        hw_en[5] = 1'b1;
        hw_data[5*DW +: DW] = 32'h1;
        issue("w1c_race", 1'b1, 32'd5, 32'h1, 4'b1111);
        hw_en = '0;
        check_eq("w1c_race_reg5", reg_of(csr_q, 5), 32'h101);
        complete("w1c_race", 0, 32'h0, 1'b0);
        issue("w1c_clr", 1'b1, 32'd5, 32'h101, 4'b1111);
        check_eq("w1c_clr_reg5", reg_of(csr_q, 5), 32'h0);
        complete("w1c_clr", 0, 32'h0, 1'b0);

        // WAC start bit pulses for one cycle (u_dut_wac); u_dut keeps it (RW)
        issue("wac", 1'b1, 32'd0, 32'h1, 4'b1111);
        check_eq("wac_pulse", reg_of(csr_q_w, 0), 32'h1);
        check_eq("wac_rw_reg0", reg_of(csr_q, 0), 32'h1);
        check_eq("wac_inst_rsp_valid", rsp_valid_w, 1);
        complete("wac", 0, 32'h0, 1'b0);
        check_eq("wac_cleared", reg_of(csr_q_w, 0), 32'h0);
        check_eq("wac_rw_hold", reg_of(csr_q, 0), 32'h1);
        check_eq("wac_inst_ready", req_ready_w, 1);

        // Errors: out of range, aliased upper bits, write to RO
        issue("err_oor", 1'b0, 32'd16, 32'h0, 4'h0);
        complete("err_oor", 0, 32'h0, 1'b1);
        issue("err_alias", 1'b0, 32'h0000_0013, 32'h0, 4'h0);
        complete("err_alias", 0, 32'h0, 1'b1);
        issue("err_ro", 1'b1, 32'd2, 32'hFFFFFFFF, 4'b1111);
        check_eq("err_ro_reg2", reg_of(csr_q, 2), 32'h1234);
        complete("err_ro", 0, 32'h0, 1'b1);
        check_eq("err_inst_wac_err", rsp_err_w, 0);

        // RO: hardware load, then a read sees it
        hw_en[2] = 1'b1;
        hw_data[2*DW +: DW] = 32'h55;
        @(posedge clk);
        #1;
        hw_en = '0;
        issue("ro_rd", 1'b0, 32'd2, 32'h0, 4'h0);
        complete("ro_rd", 0, 32'h55, 1'b0);
        check_eq("ro_rd_wac_rdata", rsp_rdata_w, 32'h0);

        // Reset while a response is pending
        issue("midrst", 1'b0, 32'd0, 32'h0, 4'h0);
        check_eq("midrst_rdata_pre", rsp_rdata, 32'h1);
        rst = 1'b1;
        #1;
        check_eq("midrst_rsp_valid", rsp_valid, 0);
        check_eq("midrst_ready", req_ready, 0);
        check_eq("midrst_reg0", reg_of(csr_q, 0), 32'hA5);
        check_eq("midrst_reg2", reg_of(csr_q, 2), 32'h1234);
        check_eq("midrst_reg3", reg_of(csr_q, 3), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_eq("postrst_ready", req_ready, 1);
        issue("postrst_rd", 1'b0, 32'd0, 32'h0, 4'h0);
        complete("postrst_rd", 0, 32'hA5, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
